// File: rtl/wave_meas.sv
// wave_meas: waveform analyser for a signed sample stream.
// It measures the period in samples between rising zero crossings, using
// hysteresis. It also reports the positive peak, the negative peak and the
// peak-to-peak value of each completed cycle.
//
// Handshake: a sample on `wave` is consumed only on clk edges where s_tick=1.
// meas_vld is a one-clock pulse that is valid without any ready. When it
// fires, period/vpk/vnk/vpp have just been updated, and they hold until the
// next pulse.
//
// dbg_state exposes the FSM state: 0=IDLE, 1=SEEK_LOW, 2=SEEK_RISE, 3=MEASURE.
module wave_meas #(
  parameter int DW      = 12,
  parameter int HYST    = 16,
  parameter int PER_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_tick,
  input  logic                 meas_en,
  input  logic signed [DW-1:0] wave,
  output logic [PER_W-1:0]     period,
  output logic signed [DW-1:0] vpk,
  output logic signed [DW-1:0] vnk,
  output logic [DW:0]          vpp,
  output logic                 meas_vld,
  output logic                 no_sig,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEEK_LOW  = 2'd1,
    SEEK_RISE = 2'd2,
    MEASURE   = 2'd3
  } state_t;

  localparam logic signed [DW-1:0] HYST_POS  = DW'(HYST);
  localparam logic signed [DW-1:0] HYST_NEG  = DW'(-HYST);
  localparam logic [PER_W-1:0]     TIMEOUT_C = PER_W'(TIMEOUT);

  state_t                state_q, state_d;
  logic [PER_W-1:0]      cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic signed [DW-1:0]  pk_q, pk_d;
  logic signed [DW-1:0]  nk_q, nk_d;
  logic [PER_W-1:0]      period_q, period_d;
  logic signed [DW-1:0]  vpk_q, vpk_d;
  logic signed [DW-1:0]  vnk_q, vnk_d;
  logic [DW:0]           vpp_q, vpp_d;
  logic                  meas_vld_q, meas_vld_d;
  logic                  no_sig_q, no_sig_d;
  logic                  busy_q, busy_d;

  logic x_hi;
  logic x_lo;
  logic [DW:0] pk_ext;
  logic [DW:0] nk_ext;

  assign x_hi   = (wave >= HYST_POS);
  assign x_lo   = (wave <= HYST_NEG);
  assign pk_ext = {pk_q[DW-1], pk_q};
  assign nk_ext = {nk_q[DW-1], nk_q};

  // Next-state logic. meas_en=0 overrides everything, including a crossing on the same edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q;
    pk_d       = pk_q;
    nk_d       = nk_q;
    period_d   = period_q;
    vpk_d      = vpk_q;
    vnk_d      = vnk_q;
    vpp_d      = vpp_q;
    meas_vld_d = 1'b0;
    no_sig_d   = no_sig_q;

    if (!meas_en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      armed_d  = 1'b0;
      no_sig_d = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = SEEK_LOW;
      cnt_d   = '0;
      armed_d = 1'b0;
    end else if (s_tick) begin
      if ((state_q == SEEK_RISE) && x_hi) begin
        // First crossing after arming: open the first measurement window.
        state_d = MEASURE;
        cnt_d   = PER_W'(1);
        pk_d    = wave;
        nk_d    = wave;
        armed_d = 1'b0;
      end else if ((state_q == MEASURE) && armed_q && x_hi) begin
        // Crossing: publish the window that just ended, then start a new one on this sample.
        period_d   = cnt_q;
        vpk_d      = pk_q;
        vnk_d      = nk_q;
        vpp_d      = pk_ext - nk_ext;
        meas_vld_d = 1'b1;
        no_sig_d   = 1'b0;
        cnt_d      = PER_W'(1);
        pk_d       = wave;
        nk_d       = wave;
        armed_d    = 1'b0;
      end else if (cnt_q == TIMEOUT_C) begin
        // Too long without a crossing: flag it and search again. Results hold.
        no_sig_d = 1'b1;
        state_d  = SEEK_LOW;
        cnt_d    = '0;
        armed_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + PER_W'(1);
        case (state_q)
          SEEK_LOW: begin
            if (x_lo) begin
              armed_d = 1'b1;
              state_d = SEEK_RISE;
            end
          end
          MEASURE: begin
            if (wave > pk_q) pk_d = wave;
            if (wave < nk_q) nk_d = wave;
            if (x_lo) armed_d = 1'b1;
          end
          default: ;
        endcase
      end
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; async active-low reset clears everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      pk_q       <= '0;
      nk_q       <= '0;
      period_q   <= '0;
      vpk_q      <= '0;
      vnk_q      <= '0;
      vpp_q      <= '0;
      meas_vld_q <= 1'b0;
      no_sig_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      pk_q       <= pk_d;
      nk_q       <= nk_d;
      period_q   <= period_d;
      vpk_q      <= vpk_d;
      vnk_q      <= vnk_d;
      vpp_q      <= vpp_d;
      meas_vld_q <= meas_vld_d;
      no_sig_q   <= no_sig_d;
      busy_q     <= busy_d;
    end
  end

  assign period    = period_q;
  assign vpk       = vpk_q;
  assign vnk       = vnk_q;
  assign vpp       = vpp_q;
  assign meas_vld  = meas_vld_q;
  assign no_sig    = no_sig_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
